// File: rtl/pc_sequencer.sv
// Parametrised next-PC unit: sequential, branch, j/jal, jr/return redirects with a return-address
// stack. Define PC_SEQ_TRACE_EN to add the redirect_count output.
module pc_sequencer #(
  parameter int unsigned          ADDR_W    = 32,
  parameter int unsigned          JIDX_W    = 26,
  parameter int unsigned          OFF_W     = 16,
  parameter logic [ADDR_W-1:0]    RESET_PC  = '0,
  parameter int unsigned          RAS_DEPTH = 4
) (
  input  logic                             clock,
  input  logic                             reset_n,
  input  logic                             stall,
  input  logic                             br_taken,
  input  logic [OFF_W-1:0]                 br_offset,
  input  logic                             j_valid,
  input  logic [JIDX_W-1:0]                j_target,
  input  logic                             j_link,
  input  logic                             jr_valid,
  input  logic [ADDR_W-1:0]                jr_target,
  input  logic                             jr_ret,
  output logic [ADDR_W-1:0]                pc,
  output logic [ADDR_W-1:0]                pc_plus1,
  output logic [$clog2(RAS_DEPTH+1)-1:0]   ras_count,
  output logic                             ras_overflow,
  output logic                             ras_underflow
`ifdef PC_SEQ_TRACE_EN
  ,
  output logic [31:0]                      redirect_count
`endif
);

  localparam int unsigned PtrW = $clog2(RAS_DEPTH);
  localparam int unsigned CntW = $clog2(RAS_DEPTH + 1);

  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] br_ext;
  logic [PtrW-1:0]   ptr_q, ptr_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic              ovf_q, ovf_d;
  logic              unf_q, unf_d;
  logic              push;
  logic              redirect;

  logic [ADDR_W-1:0] ras_mem [RAS_DEPTH];

  assign pc_plus1 = pc_q + ADDR_W'(1);
  assign br_ext   = ADDR_W'($signed(br_offset));

  // Priority: stall > jr > j > branch > sequential; only the winner touches state.
  always_comb begin
    pc_d     = pc_plus1;
    ptr_d    = ptr_q;
    cnt_d    = cnt_q;
    ovf_d    = 1'b0;
    unf_d    = 1'b0;
    push     = 1'b0;
    redirect = 1'b0;
    if (stall) begin
      pc_d = pc_q;
    end else if (jr_valid) begin
      redirect = 1'b1;
      if (jr_ret && (cnt_q != '0)) begin
        pc_d  = ras_mem[ptr_q];
        ptr_d = ptr_q - PtrW'(1);
        cnt_d = cnt_q - CntW'(1);
      end else begin
        pc_d  = jr_target;
        unf_d = jr_ret;
      end
    end else if (j_valid) begin
      redirect = 1'b1;
      pc_d     = {pc_plus1[ADDR_W-1:JIDX_W], j_target};
      if (j_link) begin
        push  = 1'b1;
        ptr_d = ptr_q + PtrW'(1);
        // A full stack overwrites its oldest slot, which is exactly ptr+1 in the ring.
        if (cnt_q == CntW'(RAS_DEPTH)) begin
          ovf_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
    end else if (br_taken) begin
      redirect = 1'b1;
      pc_d     = pc_plus1 + br_ext;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      pc_q  <= RESET_PC;
      ptr_q <= '0;
      cnt_q <= '0;
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      pc_q  <= pc_d;
      ptr_q <= ptr_d;
      cnt_q <= cnt_d;
      ovf_q <= ovf_d;
      unf_q <= unf_d;
    end
  end

  // Stack contents need no reset; only the count and pointer define validity.
  always_ff @(posedge clock) begin
    if (push) begin
      ras_mem[ptr_d] <= pc_plus1;
    end
  end

`ifdef PC_SEQ_TRACE_EN
  logic [31:0] redirect_count_q;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      redirect_count_q <= '0;
    end else if (redirect) begin
      redirect_count_q <= redirect_count_q + 32'd1;
    end
  end

  assign redirect_count = redirect_count_q;
`else
  logic unused_redirect;
  assign unused_redirect = redirect;
`endif

  assign pc            = pc_q;
  assign ras_count     = cnt_q;
  assign ras_overflow  = ovf_q;
  assign ras_underflow = unf_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Scoreboard bench for pc_sequencer: stimulus pushes hand-computed expectations, a monitor
// pops one per clock and compares.
module tb_pc_sequencer;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        stall = 1'b0, br_taken = 1'b0, j_valid = 1'b0, j_link = 1'b0;
  logic        jr_valid = 1'b0, jr_ret = 1'b0;
  logic [15:0] br_offset = '0;
  logic [25:0] j_target = '0;
  logic [31:0] jr_target = '0;
  logic [31:0] pc, pc_plus1;
  logic [2:0]  ras_count;
  logic        ras_overflow, ras_underflow;
`ifdef PC_SEQ_TRACE_EN
  logic [31:0] redirect_count;
`endif

  pc_sequencer dut (
    .clock         (clock),
    .reset_n       (reset_n),
    .stall         (stall),
    .br_taken      (br_taken),
    .br_offset     (br_offset),
    .j_valid       (j_valid),
    .j_target      (j_target),
    .j_link        (j_link),
    .jr_valid      (jr_valid),
    .jr_target     (jr_target),
    .jr_ret        (jr_ret),
    .pc            (pc),
    .pc_plus1      (pc_plus1),
    .ras_count     (ras_count),
    .ras_overflow  (ras_overflow),
    .ras_underflow (ras_underflow)
`ifdef PC_SEQ_TRACE_EN
    ,
    .redirect_count(redirect_count)
`endif
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [31:0] pc;
    int          cnt;
    bit          ovf;
    bit          unf;
    int          rc;
    string       name;
  } exp_t;

  exp_t exp_q[$];
  int   n_pass = 0;
  int   n_total = 0;
  int   exp_rc = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_total++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %h, expected %h", name, act, req);
  endtask

  // Called at a negedge: drive one cycle of inputs, queue the state expected after the next edge.
  task automatic step(input bit st, input bit jr, input bit jret, input bit j, input bit jl,
                      input bit br, input logic [31:0] jrt, input logic [25:0] jt,
                      input logic [15:0] off, input logic [31:0] e_pc, input int e_cnt,
                      input bit e_ovf, input bit e_unf, input string name);
    exp_t e;
    stall = st; jr_valid = jr; jr_ret = jret; j_valid = j; j_link = jl; br_taken = br;
    jr_target = jrt; j_target = jt; br_offset = off;
    if (!st && (jr || j || br)) exp_rc++;
    e.pc = e_pc; e.cnt = e_cnt; e.ovf = e_ovf; e.unf = e_unf; e.rc = exp_rc; e.name = name;
    exp_q.push_back(e);
    @(negedge clock);
  endtask

  task automatic seq(input logic [31:0] e_pc, input int e_cnt, input string name);
    step(0, 0, 0, 0, 0, 0, '0, '0, '0, e_pc, e_cnt, 0, 0, name);
  endtask

  task automatic jal(input logic [25:0] jt, input logic [31:0] e_pc, input int e_cnt,
                     input bit e_ovf, input string name);
    step(0, 0, 0, 1, 1, 0, '0, jt, '0, e_pc, e_cnt, e_ovf, 0, name);
  endtask

  task automatic ret(input logic [31:0] jrt, input logic [31:0] e_pc, input int e_cnt,
                     input bit e_unf, input string name);
    step(0, 1, 1, 0, 0, 0, jrt, '0, '0, e_pc, e_cnt, 0, e_unf, name);
  endtask

  always @(posedge clock) begin
    exp_t e;
    #1;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk({e.name, " pc"}, pc, e.pc);
      chk({e.name, " pc_plus1"}, pc_plus1, e.pc + 32'd1);
      chk({e.name, " ras_count"}, 32'(ras_count), 32'(e.cnt));
      chk({e.name, " ras_overflow"}, 32'(ras_overflow), 32'(e.ovf));
      chk({e.name, " ras_underflow"}, 32'(ras_underflow), 32'(e.unf));
`ifdef PC_SEQ_TRACE_EN
      chk({e.name, " redirect_count"}, redirect_count, 32'(e.rc));
`endif
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete, got running, expected finished");
    $fatal(1);
  end

  initial begin
    @(negedge clock);
    chk("reset pc", pc, 32'h0);
    chk("reset ras_count", 32'(ras_count), 32'd0);
    chk("reset flags", {30'd0, ras_overflow, ras_underflow}, 32'd0);
    reset_n = 1'b1;

    for (int i = 1; i <= 10; i++) seq(32'(i), 0, "sequential");
    step(0, 0, 0, 0, 0, 1, '0, '0, 16'hFFFB, 32'd6, 0, 0, 0, "branch back");
    step(0, 0, 0, 0, 0, 1, '0, '0, 16'h0004, 32'd11, 0, 0, 0, "branch fwd");

    // Asynchronous reset asserted between edges takes effect immediately.
    #2 reset_n = 1'b0;
    #1 chk("async reset pc", pc, 32'h0);
    chk("async reset count", 32'(ras_count), 32'd0);
    @(negedge clock);
    reset_n = 1'b1;
    exp_rc = 0;
    seq(32'd1, 0, "after reset");

    step(0, 1, 0, 0, 0, 0, 32'h4000_0005, '0, '0, 32'h4000_0005, 0, 0, 0, "jr plain");
    jal(26'h0000100, 32'h4000_0100, 1, 0, "jal");
    ret(32'h0, 32'h4000_0006, 0, 0, "return");

    jal(26'h10, 32'h4000_0010, 1, 0, "jal1");
    jal(26'h20, 32'h4000_0020, 2, 0, "jal2");
    jal(26'h30, 32'h4000_0030, 3, 0, "jal3");
    jal(26'h40, 32'h4000_0040, 4, 0, "jal4");
    jal(26'h50, 32'h4000_0050, 4, 1, "jal5 overflow");
    ret(32'h1234, 32'h4000_0041, 3, 0, "ret1");
    ret(32'h1234, 32'h4000_0031, 2, 0, "ret2");
    ret(32'h1234, 32'h4000_0021, 1, 0, "ret3");
    ret(32'h1234, 32'h4000_0011, 0, 0, "ret4");
    ret(32'h1234, 32'h0000_1234, 0, 1, "ret5 underflow");
    seq(32'h1235, 0, "flag clear");

    jal(26'h200, 32'h200, 1, 0, "jal pre-stall");
    step(1, 1, 1, 1, 1, 1, 32'h999, 26'h5, 16'h7, 32'h200, 1, 0, 0, "stall all");
    step(0, 1, 0, 1, 1, 0, 32'h777, 26'h5, '0, 32'h777, 1, 0, 0, "jr beats jal");
    ret(32'h0, 32'h1236, 0, 0, "ret no extra push");

    step(0, 1, 0, 0, 0, 0, 32'hFFFF_FFFF, '0, '0, 32'hFFFF_FFFF, 0, 0, 0, "jr all ones");
    seq(32'h0, 0, "wrap");
    step(0, 0, 0, 0, 0, 1, '0, '0, 16'hFFFE, 32'hFFFF_FFFF, 0, 0, 0, "branch wrap");

    // Trace mix: 2 branches, 1 jump, 1 stalled jr, 3 sequential.
    exp_rc = 0;
    #2 reset_n = 1'b0;
    @(negedge clock);
    reset_n = 1'b1;
    step(0, 0, 0, 0, 0, 1, '0, '0, 16'h0002, 32'd3, 0, 0, 0, "trace br1");
    step(0, 0, 0, 0, 0, 1, '0, '0, 16'h0002, 32'd6, 0, 0, 0, "trace br2");
    step(0, 0, 0, 1, 0, 0, '0, 26'h40, '0, 32'h40, 0, 0, 0, "trace j");
    step(1, 1, 0, 0, 0, 0, 32'h88, '0, '0, 32'h40, 0, 0, 0, "trace stalled jr");
    seq(32'h41, 0, "trace seq1");
    seq(32'h42, 0, "trace seq2");
    seq(32'h43, 0, "trace seq3");
    chk("trace model count", 32'(exp_rc), 32'd3);

    @(negedge clock);
    @(negedge clock);
    chk("scoreboard drained", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
